// File: rtl/exe_operand_stage.sv
// ID->EX operand register feeding the 64-bit ALU: one-entry skid with MEM/WB
// forwarding, load-use stall and capture of retiring WB values while held.

module exe_operand_fwd #(
  parameter int XLEN      = 64,
  parameter int REG_IDX_W = 5
) (
  input  logic [REG_IDX_W-1:0] src_idx_i,
  input  logic [XLEN-1:0]      src_data_i,
  input  logic                 mem_rd_wen_i,
  input  logic [REG_IDX_W-1:0] mem_rd_idx_i,
  input  logic [XLEN-1:0]      mem_rd_data_i,
  input  logic                 mem_is_load_i,
  input  logic                 wb_rd_wen_i,
  input  logic [REG_IDX_W-1:0] wb_rd_idx_i,
  input  logic [XLEN-1:0]      wb_rd_data_i,
  output logic [XLEN-1:0]      fwd_data_o,
  output logic                 mem_load_hit_o,
  output logic                 wb_hit_o
);
  logic nz, mem_hit;

  assign nz             = (src_idx_i != '0);
  assign mem_hit        = nz && mem_rd_wen_i && (mem_rd_idx_i == src_idx_i);
  assign wb_hit_o       = nz && wb_rd_wen_i && (wb_rd_idx_i == src_idx_i);
  assign mem_load_hit_o = mem_hit && mem_is_load_i;

  // A load in MEM has no data yet, so it falls through to WB/stored.
  always_comb begin
    fwd_data_o = src_data_i;
    if (mem_hit && !mem_is_load_i) fwd_data_o = mem_rd_data_i;
    else if (wb_hit_o)             fwd_data_o = wb_rd_data_i;
  end
endmodule

module exe_operand_stage #(
  parameter int XLEN      = 64,
  parameter int REG_IDX_W = 5,
  parameter int SEL_W     = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [XLEN-1:0]      in_imm,
  input  logic [REG_IDX_W-1:0] in_rs1_idx,
  input  logic [REG_IDX_W-1:0] in_rs2_idx,
  input  logic [XLEN-1:0]      in_rs1_data,
  input  logic [XLEN-1:0]      in_rs2_data,
  input  logic [1:0]           in_a_sel,
  input  logic                 in_b_sel,
  input  logic [SEL_W-1:0]     in_alu_sel,
  input  logic [REG_IDX_W-1:0] in_rd_idx,
  input  logic                 in_rd_wen,
  input  logic                 flush,
  input  logic                 mem_rd_wen,
  input  logic [REG_IDX_W-1:0] mem_rd_idx,
  input  logic [XLEN-1:0]      mem_rd_data,
  input  logic                 mem_is_load,
  input  logic                 wb_rd_wen,
  input  logic [REG_IDX_W-1:0] wb_rd_idx,
  input  logic [XLEN-1:0]      wb_rd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      alu_a,
  output logic [XLEN-1:0]      alu_b,
  output logic [SEL_W-1:0]     alu_sel,
  output logic [REG_IDX_W-1:0] out_rd_idx,
  output logic                 out_rd_wen,
  output logic [XLEN-1:0]      out_pc
);
  localparam int NSRC = 2;

  typedef struct packed {
    logic [XLEN-1:0]                 pc;
    logic [XLEN-1:0]                 imm;
    logic [NSRC-1:0][REG_IDX_W-1:0]  rs_idx;
    logic [NSRC-1:0][XLEN-1:0]       rs_data;
    logic [1:0]                      a_sel;
    logic                            b_sel;
    logic [SEL_W-1:0]                alu_sel;
    logic [REG_IDX_W-1:0]            rd_idx;
    logic                            rd_wen;
  } entry_t;

  entry_t ent_q, ent_d;
  logic   valid_q, valid_d;

  logic [NSRC-1:0][XLEN-1:0] fwd_data;
  logic [NSRC-1:0]           load_hit, wb_hit, used;
  logic                      hazard, fire, accept;

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    exe_operand_fwd #(.XLEN(XLEN), .REG_IDX_W(REG_IDX_W)) u_fwd (
      .src_idx_i      (ent_q.rs_idx[s]),
      .src_data_i     (ent_q.rs_data[s]),
      .mem_rd_wen_i   (mem_rd_wen),
      .mem_rd_idx_i   (mem_rd_idx),
      .mem_rd_data_i  (mem_rd_data),
      .mem_is_load_i  (mem_is_load),
      .wb_rd_wen_i    (wb_rd_wen),
      .wb_rd_idx_i    (wb_rd_idx),
      .wb_rd_data_i   (wb_rd_data),
      .fwd_data_o     (fwd_data[s]),
      .mem_load_hit_o (load_hit[s]),
      .wb_hit_o       (wb_hit[s])
    );
  end

  // Only sources the operand mux actually selects can stall the entry.
  assign used[0] = (ent_q.a_sel == 2'b00) || (ent_q.a_sel == 2'b11);
  assign used[1] = !ent_q.b_sel;
  assign hazard  = valid_q && |(load_hit & used);

  assign out_valid = valid_q && !hazard && !flush;
  assign fire      = out_valid && out_ready;
  assign in_ready  = !valid_q || fire;
  assign accept    = in_valid && in_ready && !flush;

  always_comb begin
    alu_a = fwd_data[0];
    case (ent_q.a_sel)
      2'b01:   alu_a = ent_q.pc;
      2'b10:   alu_a = '0;
      default: alu_a = fwd_data[0];
    endcase
  end

  assign alu_b      = ent_q.b_sel ? ent_q.imm : fwd_data[1];
  assign alu_sel    = ent_q.alu_sel;
  assign out_rd_idx = ent_q.rd_idx;
  assign out_rd_wen = ent_q.rd_wen;
  assign out_pc     = ent_q.pc;

  always_comb begin
    valid_d = valid_q;
    ent_d   = ent_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d          = 1'b1;
      ent_d.pc         = in_pc;
      ent_d.imm        = in_imm;
      ent_d.rs_idx[0]  = in_rs1_idx;
      ent_d.rs_idx[1]  = in_rs2_idx;
      ent_d.rs_data[0] = in_rs1_data;
      ent_d.rs_data[1] = in_rs2_data;
      ent_d.a_sel      = in_a_sel;
      ent_d.b_sel      = in_b_sel;
      ent_d.alu_sel    = in_alu_sel;
      ent_d.rd_idx     = in_rd_idx;
      ent_d.rd_wen     = in_rd_wen;
    end else if (fire) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      // A value retiring from WB while we wait would otherwise be lost.
      for (int s = 0; s < NSRC; s++)
        if (wb_hit[s]) ent_d.rs_data[s] = wb_rd_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      ent_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ent_q   <= ent_d;
    end
  end
endmodule
